instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 124 ++++++++++++
 tb/tb_instruction_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
// instruction_fetch: fetch stage in front of a 1-cycle-latency program memory.
// Owns the fetch PC, keeps a 3-entry {instr, pc} queue toward decode, flushes
// on redirect and stops fetching after delivering an all-zero instruction word.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN. When it is defined, a
// misaligned redirect target parks the stage in ERR and sets a sticky
// fetch_err. When it is not defined, the low two target bits are ignored.
module instruction_fetch #(
    parameter int                  PC_WIDTH  = 12,
    parameter int                  OPD_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_WIDTH-1:0]  pmem_addr,
    input  logic [31:0]          pmem_data,
    input  logic [OPD_WIDTH-1:0] pmem_pc,
    input  logic                 redirect,
    input  logic [PC_WIDTH-1:0]  redirect_target,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          instr,
    output logic [OPD_WIDTH-1:0] instr_pc,
    output logic                 halted,
    output logic                 fetch_err
);

    typedef struct packed {
        logic [31:0]          word;
        logic [OPD_WIDTH-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                inflight;
    entry_t              q [3];      // q[0] is always the head
    logic [1:0]          count;

    logic                pop;
    logic                push;
    logic                issue;
    logic                halt_now;
    logic                misaligned;
    logic [PC_WIDTH-1:0] target;
    logic [1:0]          wr_idx;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign misaligned = (redirect_target[1:0] != 2'b00);
    assign target     = redirect_target;
`else
    assign misaligned = 1'b0;
    assign target     = redirect_target & ~PC_WIDTH'(3);
`endif

    assign pop      = (count != 2'd0) && instr_ready;
    assign push     = inflight;
    assign halt_now = pop && (q[0].word == 32'h0);
    // Only issue if the word can be stored even when decode does not pop.
    assign issue    = (state == RUN) && (({1'b0, count} + {2'b0, inflight}) < 3'd3);
    // A pop shifts the queue down, so the returning word lands one slot lower.
    assign wr_idx   = count - {1'b0, pop};

    assign pmem_addr   = fetch_pc;
    assign instr_valid = (count != 2'd0);
    assign instr       = q[0].word;
    assign instr_pc    = q[0].pc;

    // Fetch control, queue storage and RUN/HALT/ERR state; redirect has top priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            inflight  <= 1'b0;
            count     <= 2'd0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            // NOTE: the queue entries are reset because instr/instr_pc must read 0
            // out of reset; with only three entries the reset cost is negligible.
            for (int i = 0; i < 3; i++) begin
                q[i] <= '0;
            end
        end else if (redirect) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            fetch_pc <= target;
            halted   <= 1'b0;
            if (misaligned) begin
                state     <= ERR;
                fetch_err <= 1'b1;
            end else begin
                state <= RUN;
            end
        end else if (halt_now) begin
            // The zero word has just been handed to decode; drop everything behind it.
            state    <= HALT;
            halted   <= 1'b1;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (pop) begin
                for (int i = 0; i < 2; i++) begin
                    q[i] <= q[i+1];
                end
            end
            // NOTE: non-blocking assignments make the later push win over the shift
            // when both target the same slot, which is exactly push-behind-pop order.
            if (push) begin
                q[wr_idx] <= {pmem_data, pmem_pc};
            end
            count    <= count + {1'b0, push} - {1'b0, pop};
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// Testbench for instruction_fetch: program memory model, scoreboard of the
// expected instruction stream, and directed timing checks with random stalls.
module tb_instruction_fetch;

    localparam int PC_WIDTH  = 12;
    localparam int OPD_WIDTH = 32;
    localparam int MEM_WORDS = 1 << (PC_WIDTH - 2);
    localparam int PC_SPAN   = 1 << PC_WIDTH;
    localparam int HALT_ADDR = 204;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [PC_WIDTH-1:0]  pmem_addr;
    logic [31:0]          pmem_data = '0;
    logic [OPD_WIDTH-1:0] pmem_pc = '0;
    logic                 redirect = 1'b0;
    logic [PC_WIDTH-1:0]  redirect_target = '0;
    logic                 instr_valid;
    logic                 instr_ready = 1'b0;
    logic [31:0]          instr;
    logic [OPD_WIDTH-1:0] instr_pc;
    logic                 halted;
    logic                 fetch_err;

    instruction_fetch #(
        .PC_WIDTH (PC_WIDTH),
        .OPD_WIDTH(OPD_WIDTH),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst            (rst_n),
        .pmem_addr      (pmem_addr),
        .pmem_data      (pmem_data),
        .pmem_pc        (pmem_pc),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // Program memory: one-cycle read latency, echoes the address with the data.
    logic [31:0] mem [MEM_WORDS];
    always @(posedge clk) begin
        pmem_data <= mem[pmem_addr[PC_WIDTH-1:2]];
        pmem_pc   <= OPD_WIDTH'(pmem_addr);
    end

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // The delivered stream after a restart is the program in address order,
    // wrapping at the top of memory and ending with the first zero word.
    task automatic push_stream(input int start);
        int   pc;
        exp_t e;
        pc = start;
        for (int n = 0; n < MEM_WORDS + 1; n++) begin
            e.word = mem[pc / 4];
            e.pc   = pc;
            exp_q.push_back(e);
            if (e.word == 32'h0) break;
            pc = (pc + 4) % PC_SPAN;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert redirect for one edge; stream_start < 0 means nothing is expected afterwards.
    task automatic do_redirect(input int target, input int stream_start);
        redirect        = 1'b1;
        redirect_target = PC_WIDTH'(target);
        exp_q.delete();
        if (stream_start >= 0) push_stream(stream_start);
        tick();
        redirect = 1'b0;
    endtask

    // Monitor: every accepted (non-flushed) instruction must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc %0h word %0h, expected no instruction (t=%0t)",
                         instr_pc, instr, $time);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", instr_pc, e.pc);
                check("pop_word", instr, e.word);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PC_WIDTH-1:0] halt_addr;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom | 32'h1;
        mem[HALT_ADDR / 4] = 32'h0;

        // Reset state and first fetch timing.
        instr_ready = 1'b1;
        repeat (2) tick();
        check("rst_pmem_addr", 32'(pmem_addr), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        exp_q.delete();
        push_stream(0);
        rst_n = 1'b1;
        tick();
        check("cycle1_valid", 32'(instr_valid), 0);
        check("cycle1_addr", 32'(pmem_addr), 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stream_valid", 32'(instr_valid), 1);
            check("stream_pc", instr_pc, 32'(4 * k));
        end

        // Asynchronous reset mid-operation, then a decode stall.
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", 32'(pmem_addr), 0);
        check("async_rst_valid", 32'(instr_valid), 0);
        check("async_rst_instr_pc", instr_pc, 0);
        instr_ready = 1'b0;
        exp_q.delete();
        push_stream(0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("stall_first_valid", 32'(instr_valid), 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_addr_frozen", 32'(pmem_addr), 12);
            check("stall_head_pc", instr_pc, 0);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("release_no_gap", 32'(instr_valid), 1);
        end

        // Random decode back-pressure.
        repeat (30) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Redirect with a full queue and a same-cycle pop.
        instr_ready = 1'b0;
        repeat (6) tick();
        instr_ready = 1'b1;
        do_redirect(104, 104);
        check("redir_valid_r1", 32'(instr_valid), 0);
        check("redir_addr", 32'(pmem_addr), 104);
        tick();
        check("redir_valid_r2", 32'(instr_valid), 0);
        tick();
        check("redir_valid_r3", 32'(instr_valid), 1);
        check("redir_pc", instr_pc, 104);

        // Run into the zero word at HALT_ADDR.
        for (int k = 0; k < 80; k++) begin
            if (halted) break;
            tick();
        end
        check("halt_reached", 32'(halted), 1);
        check("halt_all_delivered", 32'(exp_q.size()), 0);
        halt_addr = pmem_addr;
        repeat (5) begin
            tick();
            check("halt_valid", 32'(instr_valid), 0);
            check("halt_addr_static", 32'(pmem_addr), 32'(halt_addr));
        end

        // Restart from HALT.
        do_redirect(140, 140);
        check("unhalt", 32'(halted), 0);
        tick();
        check("unhalt_valid_r2", 32'(instr_valid), 0);
        tick();
        check("unhalt_pc", instr_pc, 140);
        repeat (20) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // PC wraps at the top of program memory.
        instr_ready = 1'b1;
        do_redirect(PC_SPAN - 4, PC_SPAN - 4);
        check("wrap_addr_top", 32'(pmem_addr), 32'(PC_SPAN - 4));
        tick();
        check("wrap_addr_zero", 32'(pmem_addr), 0);
        tick();
        check("wrap_pc", instr_pc, 32'(PC_SPAN - 4));
        repeat (10) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Misaligned redirect.
        instr_ready = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
        do_redirect(6, -1);
        check("misalign_err", 32'(fetch_err), 1);
        repeat (6) begin
            tick();
            check("misalign_no_valid", 32'(instr_valid), 0);
        end
        do_redirect(8, 8);
        tick();
        tick();
        check("err_resume_pc", instr_pc, 8);
        check("err_sticky", 32'(fetch_err), 1);
`else
        do_redirect(6, 4);
        check("misalign_no_err", 32'(fetch_err), 0);
        check("misalign_addr", 32'(pmem_addr), 4);
        tick();
        tick();
        check("misalign_pc", instr_pc, 4);
`endif
        repeat (10) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
